// File: rtl/wave_pkg.sv
// Shared definitions for the waveform program encoder: opcodes, word widths,
// run classes, encoder states and small helpers for classification.
package wave_pkg;

    localparam int PARAM_SIZE = 8;
    localparam int OP_SIZE    = 3;
    localparam int WORD_SIZE  = OP_SIZE + PARAM_SIZE;

    localparam logic [OP_SIZE-1:0] C_NOP  = 3'd0;
    localparam logic [OP_SIZE-1:0] C_LINE = 3'd1;
    localparam logic [OP_SIZE-1:0] C_INCR = 3'd2;
    localparam logic [OP_SIZE-1:0] C_DCRE = 3'd3;
    localparam logic [OP_SIZE-1:0] C_JUMP = 3'd4;

    typedef enum logic [1:0] {
        CLASS_LINE,
        CLASS_INCR,
        CLASS_DCRE,
        CLASS_JUMP
    } run_class_t;

    typedef enum logic {
        IDLE,
        RUN
    } enc_state_t;

    // Opcode emitted for a run of the given class.
    function automatic logic [OP_SIZE-1:0] class_op(input run_class_t cls);
        case (cls)
            CLASS_LINE: class_op = C_LINE;
            CLASS_INCR: class_op = C_INCR;
            CLASS_DCRE: class_op = C_DCRE;
            default:    class_op = C_JUMP;
        endcase
    endfunction

    // Classify the modulo-256 step between consecutive samples.
    function automatic run_class_t classify(input logic [PARAM_SIZE-1:0] diff);
        case (diff)
            8'd0:    classify = CLASS_LINE;
            8'd1:    classify = CLASS_INCR;
            8'd255:  classify = CLASS_DCRE;
            default: classify = CLASS_JUMP;
        endcase
    endfunction

endpackage

// File: rtl/wave_out_fifo.sv
// Two-entry output queue of {op, param} words; accepts up to two pushes and
// one pop per cycle. Pops are applied before pushes within a cycle.
module wave_out_fifo
    import wave_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           push_count,
    input  logic [WORD_SIZE-1:0] push_word0,
    input  logic [WORD_SIZE-1:0] push_word1,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] head,
    output logic                 empty
);

    logic [WORD_SIZE-1:0] slot0;
    logic [WORD_SIZE-1:0] slot1;
    logic [1:0]           count;
    logic [WORD_SIZE-1:0] slot0_n;
    logic [WORD_SIZE-1:0] slot1_n;
    logic [1:0]           count_n;

    // Compute next contents: drop the head on pop, then append new words in order.
    always_comb begin
        slot0_n = slot0;
        slot1_n = slot1;
        count_n = count;
        if (pop && count != 2'd0) begin
            slot0_n = slot1;
            count_n = count - 2'd1;
        end
        if (push_count != 2'd0) begin
            if (count_n == 2'd0) begin
                slot0_n = push_word0;
            end else begin
                slot1_n = push_word0;
            end
            count_n = count_n + 2'd1;
        end
        if (push_count[1]) begin
            slot1_n = push_word1;
            count_n = count_n + 2'd1;
        end
    end

    // Storage registers; reset clears the queue and the visible head word.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            slot0 <= slot0_n;
            slot1 <= slot1_n;
            count <= count_n;
        end
    end

    assign head  = slot0;
    assign empty = (count == 2'd0);

endmodule

// File: rtl/wave_program_encoder.sv
// Compresses a DAC sample stream into waveform program words (JUMP, INCR,
// DCRE, LINE run-length runs). Input is accepted only while the output
// queue is empty, so one cycle's pushes always fit in the queue.
module wave_program_encoder
    import wave_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [PARAM_SIZE-1:0] sample_data,
    output logic                  sample_ready,
    input  logic                  flush,
    output logic                  instr_valid,
    output logic [OP_SIZE-1:0]    instr_op,
    output logic [PARAM_SIZE-1:0] instr_param,
    input  logic                  instr_ready
);

    enc_state_t            state, state_n;
    logic [PARAM_SIZE-1:0] prev, prev_n;
    logic [PARAM_SIZE-1:0] count, count_n;
    run_class_t            run_cls, run_cls_n;
    logic [PARAM_SIZE-1:0] diff;
    run_class_t            sample_cls;
    logic [1:0]            push_count;
    logic [WORD_SIZE-1:0]  word0, word1;
    logic [WORD_SIZE-1:0]  head;
    logic                  fifo_empty;
    logic                  sample_acc, flush_acc;

    assign sample_ready = fifo_empty && !reset;
    assign sample_acc   = sample_valid && sample_ready;
    assign flush_acc    = flush && sample_ready;
    assign instr_valid  = !fifo_empty;
    assign instr_op     = head[WORD_SIZE-1:PARAM_SIZE];
    assign instr_param  = head[PARAM_SIZE-1:0];

    // Encoder state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            prev    <= '0;
            count   <= '0;
            run_cls <= CLASS_LINE;
        end else begin
            state   <= state_n;
            prev    <= prev_n;
            count   <= count_n;
            run_cls <= run_cls_n;
        end
    end

    // Next-state and pushed words: the sample is handled first, then a same-cycle flush closes the run.
    always_comb begin
        state_n    = state;
        prev_n     = prev;
        count_n    = count;
        run_cls_n  = run_cls;
        push_count = 2'd0;
        word0      = '0;
        word1      = '0;
        diff       = sample_data - prev;
        sample_cls = classify(diff);

        if (sample_acc) begin
            prev_n = sample_data;
            if (state == IDLE) begin
                word0      = {C_JUMP, sample_data};
                push_count = 2'd1;
                count_n    = '0;
                state_n    = RUN;
            end else if (sample_cls == CLASS_JUMP) begin
                if (count != '0) begin
                    word0      = {class_op(run_cls), count};
                    word1      = {C_JUMP, sample_data};
                    push_count = 2'd2;
                end else begin
                    word0      = {C_JUMP, sample_data};
                    push_count = 2'd1;
                end
                count_n = '0;
            end else if (count == '0) begin
                run_cls_n = sample_cls;
                count_n   = 8'd1;
            end else if (sample_cls != run_cls) begin
                word0      = {class_op(run_cls), count};
                push_count = 2'd1;
                run_cls_n  = sample_cls;
                count_n    = 8'd1;
            end else if (count == 8'd255) begin
                word0      = {class_op(run_cls), count};
                push_count = 2'd1;
                count_n    = 8'd1;
            end else begin
                count_n = count + 8'd1;
            end
        end

        if (flush_acc) begin
            if (count_n != '0) begin
                if (push_count == 2'd0) begin
                    word0 = {class_op(run_cls_n), count_n};
                end else begin
                    word1 = {class_op(run_cls_n), count_n};
                end
                push_count = push_count + 2'd1;
            end
            state_n = IDLE;
            count_n = '0;
        end
    end

    wave_out_fifo u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_count (push_count),
        .push_word0 (word0),
        .push_word1 (word1),
        .pop        (instr_valid && instr_ready),
        .head       (head),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_wave_program_encoder.sv
// Directed scoreboard bench for the waveform program encoder: expected words
// are queued as each sequence is driven and compared as the DUT hands them off.
module tb_wave_program_encoder;
    import wave_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_data = 8'd0;
    logic       sample_ready;
    logic       flush = 1'b0;
    logic       instr_valid;
    logic [2:0] instr_op;
    logic [7:0] instr_param;
    logic       instr_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_exp;
    logic [10:0] held_word;

    wave_program_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .flush        (flush),
        .instr_valid  (instr_valid),
        .instr_op     (instr_op),
        .instr_param  (instr_param),
        .instr_ready  (instr_ready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] word(input logic [2:0] op, input logic [7:0] param);
        return {op, param};
    endfunction

    // Wait (bounded) for sample_ready, present one sample and/or flush for one cycle.
    task automatic apply_stimulus(input logic [7:0] s, input logic v, input logic fl);
        int n = 0;
        while (!sample_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("sample_ready_wait", {10'd0, sample_ready}, 11'd1);
        sample_valid = v;
        sample_data  = s;
        flush        = fl;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        flush        = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to drain.
    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output(tag, 11'(exp_q.size()), 11'd0);
    endtask

    // Scoreboard monitor: compare each handed-off word against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_word: got %0h expected none", {instr_op, instr_param});
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check_output("instr_word", {instr_op, instr_param}, mon_exp);
            end
        end
    end

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("reset_valid", {10'd0, instr_valid}, 11'd0);
        check_output("reset_word", {instr_op, instr_param}, 11'd0);
        check_output("reset_ready", {10'd0, sample_ready}, 11'd0);
        reset = 1'b0;
        #1;
        check_output("ready_after_reset", {10'd0, sample_ready}, 11'd1);

        // Ramp
        $display("[TB] ramp");
        exp_q.push_back(word(C_JUMP, 8'd10));
        exp_q.push_back(word(C_INCR, 8'd3));
        apply_stimulus(8'd10, 1'b1, 1'b0);
        apply_stimulus(8'd11, 1'b1, 1'b0);
        apply_stimulus(8'd12, 1'b1, 1'b0);
        apply_stimulus(8'd13, 1'b1, 1'b0);
        apply_stimulus(8'd0, 1'b0, 1'b1);
        drain("ramp_drain");

        // Hold and fall
        $display("[TB] hold and fall");
        exp_q.push_back(word(C_JUMP, 8'd50));
        exp_q.push_back(word(C_LINE, 8'd2));
        exp_q.push_back(word(C_DCRE, 8'd2));
        apply_stimulus(8'd50, 1'b1, 1'b0);
        apply_stimulus(8'd50, 1'b1, 1'b0);
        apply_stimulus(8'd50, 1'b1, 1'b0);
        apply_stimulus(8'd49, 1'b1, 1'b0);
        apply_stimulus(8'd48, 1'b1, 1'b0);
        apply_stimulus(8'd0, 1'b0, 1'b1);
        drain("hold_drain");

        // Wrap-around, flush in the same cycle as the last sample (two pushes)
        $display("[TB] wrap-around");
        exp_q.push_back(word(C_JUMP, 8'd0));
        exp_q.push_back(word(C_DCRE, 8'd1));
        exp_q.push_back(word(C_INCR, 8'd1));
        apply_stimulus(8'd0, 1'b1, 1'b0);
        apply_stimulus(8'd255, 1'b1, 1'b0);
        apply_stimulus(8'd0, 1'b1, 1'b1);
        drain("wrap_drain");

        // Jump with run open: two words pushed together, input stalls until both drain
        $display("[TB] jump with open run");
        exp_q.push_back(word(C_JUMP, 8'd20));
        exp_q.push_back(word(C_INCR, 8'd1));
        exp_q.push_back(word(C_JUMP, 8'd200));
        apply_stimulus(8'd20, 1'b1, 1'b0);
        apply_stimulus(8'd21, 1'b1, 1'b0);
        apply_stimulus(8'd200, 1'b1, 1'b0);
        check_output("jump_ready_0", {10'd0, sample_ready}, 11'd0);
        check_output("jump_head_0", {instr_op, instr_param}, word(C_INCR, 8'd1));
        @(posedge clk);
        #1;
        check_output("jump_ready_1", {10'd0, sample_ready}, 11'd0);
        check_output("jump_head_1", {instr_op, instr_param}, word(C_JUMP, 8'd200));
        @(posedge clk);
        #1;
        check_output("jump_ready_2", {10'd0, sample_ready}, 11'd1);
        apply_stimulus(8'd0, 1'b0, 1'b1);
        apply_stimulus(8'd0, 1'b0, 1'b1);
        drain("jump_drain");

        // Saturation, followed by a flush in IDLE that must emit nothing
        $display("[TB] saturation");
        exp_q.push_back(word(C_JUMP, 8'd7));
        exp_q.push_back(word(C_LINE, 8'd255));
        exp_q.push_back(word(C_LINE, 8'd1));
        for (int i = 0; i < 257; i++) begin
            apply_stimulus(8'd7, 1'b1, 1'b0);
        end
        apply_stimulus(8'd0, 1'b0, 1'b1);
        apply_stimulus(8'd0, 1'b0, 1'b1);
        drain("sat_drain");

        // Backpressure then reset: queued words are discarded
        $display("[TB] backpressure and reset");
        instr_ready = 1'b0;
        apply_stimulus(8'd30, 1'b1, 1'b0);
        held_word = {instr_op, instr_param};
        check_output("bp_first_word", held_word, word(C_JUMP, 8'd30));
        sample_valid = 1'b1;
        sample_data  = 8'd31;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_output("bp_ready_low", {10'd0, sample_ready}, 11'd0);
            check_output("bp_word_stable", {instr_op, instr_param}, held_word);
        end
        sample_data = 8'd90;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_output("bp_word_stable", {instr_op, instr_param}, held_word);
        end
        sample_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_valid", {10'd0, instr_valid}, 11'd0);
        check_output("rst_word", {instr_op, instr_param}, 11'd0);
        check_output("rst_ready", {10'd0, sample_ready}, 11'd0);
        reset = 1'b0;
        instr_ready = 1'b1;
        #1;
        check_output("rst_ready_after", {10'd0, sample_ready}, 11'd1);

        // Post-reset sequence confirms nothing stale emerges
        $display("[TB] post-reset");
        exp_q.push_back(word(C_JUMP, 8'd1));
        exp_q.push_back(word(C_INCR, 8'd1));
        apply_stimulus(8'd1, 1'b1, 1'b0);
        apply_stimulus(8'd2, 1'b1, 1'b0);
        apply_stimulus(8'd0, 1'b0, 1'b1);
        drain("post_drain");
        repeat (4) @(posedge clk);
        #1;
        check_output("final_idle", {10'd0, instr_valid}, 11'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
